alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Multi-cycle issue/writeback controller on the driving side of the combinational ALU in the single-cycle core. It accepts R-type instruction words over a valid/ready handshake and decodes the funct field into the 6-bit ALU operation code. It reads operands from an internal 32x32 register file, drives the ALU operand and op ports, then captures the result and the zero/negative flags. It writes the result back to the destination register and reports completion.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired to zero.
- XLEN, 32, datapath width.

Ports:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- instr_valid_i  in  1  instruction word valid.
- instr_ready_o  out  1  controller can accept an instruction.
- instr_i  in  32  instruction word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [10:6] shamt, [5:0] funct.
- opr_a_alu_o  out  32  ALU operand A.
- opr_b_alu_o  out  32  ALU operand B.
- op_alu_o  out  6  ALU operation code.
- res_alu_i  in  32  ALU result.
- z_alu_i  in  1  ALU zero flag.
- n_alu_i  in  1  ALU negative flag.
- done_o  out  1  one-cycle pulse at the end of every accepted instruction.
- illegal_o  out  1  qualified by done_o; the instruction was not executed.
- res_o  out  32  written-back value; holds its value until the next done_o.
- z_o, n_o  out  1 each  registered flags of the last legal instruction.
- dbg_addr_i  in  5  register-file debug read address.
- dbg_data_o  out  32  combinational read of register dbg_addr_i; address 0 reads 0.

## Operation
- Opcodes (funct values): ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010, SLTU 101011, SHL 000010, LSR 000011, ASR 000100. op_alu_o is the funct value unchanged.
- An instruction is legal only when opcode == 000000 and funct is in this list. Any other instruction is illegal.
- Operand A is R[rs].
- Operand B is R[rt] for non-shift ops. For SHL/LSR/ASR, operand B is {27'b0, shamt} and the rt field is ignored.
- FSM states: IDLE, READ, EXEC, WB.
  - IDLE: instr_ready_o=1. On a handshake, latch instr_i, then go to READ.
  - READ: register the decoded op and both operands. Set the illegal flag.
  - EXEC: drive opr_a_alu_o, opr_b_alu_o and op_alu_o from the registers. Sample res_alu_i, z_alu_i and n_alu_i at the end of the cycle.
  - WB, legal instruction: write R[rd] (suppressed when rd==0), update res_o, z_o and n_o, pulse done_o. Return to IDLE.
  - WB, illegal instruction: no register write, no update of res_o, z_o or n_o. Pulse done_o with illegal_o=1. Return to IDLE.
- Outside EXEC, the ALU ports hold their last values. Their contents are don't-care to the bench.
- Operands are read in READ, so a write-back to rd is visible to the next instruction. No forwarding is needed because only one instruction is in flight.

## Timing
- Reset:
  - State goes to IDLE.
  - All registers R[1..31] are cleared to 0.
  - res_o=0, z_o=0, n_o=0, done_o=0, illegal_o=0.
  - instr_ready_o=1 in the first cycle after reset deasserts.
  - ALU outputs are 0.
- Latency: handshake in cycle N; READ N+1, EXEC N+2, WB N+3 (done_o high in N+3). The next handshake is possible in N+4.
- Throughput: one instruction per 4 cycles.
- instr_ready_o is low in READ, EXEC and WB. instr_valid_i is ignored while ready is low. instr_i is sampled only on the handshake edge.
- Reset has priority over everything. Reset asserted in any state aborts the instruction in flight: no write-back, no done_o.
- dbg_data_o reflects a write-back from the cycle after the WB edge.
- done_o is never high for two consecutive cycles.

## Test plan
- Reset then ADD: preload R1=5 and R2=7 via SHL/ADD sequences. Execute ADD rd=3, rs=1, rt=2 -> done_o 3 cycles after the handshake, res_o=12, z_o=0, dbg R3=12.
- SUB to zero: R4=R3-R3 -> res_o=0, z_o=1. SLT with R1=0xFFFFFFFF, R2=1 -> R[rd]=1. SLTU with the same operands -> R[rd]=0.
- Shifts: R1=0x80000000.
  - ASR shamt=4 -> 0xF8000000.
  - LSR shamt=4 -> 0x08000000.
  - SHL shamt=1 -> 0.
  - The rt field is set to a nonzero register and must be ignored.
- rd=0 and illegal cases:
  - ADD with rd=0 -> done_o=1, R0 still reads 0.
  - opcode 001000 -> done_o with illegal_o=1; res_o, z_o, n_o and all registers unchanged.
  - funct 111111 -> same as opcode 001000.
- Handshake: hold instr_valid_i high with back-to-back words -> one acceptance every 4 cycles, in order, with no word dropped or duplicated. Changes to instr_i while ready is low have no effect.
- Reset mid-operation: assert rst_i during EXEC of ADD rd=5 -> no done_o, R5=0, instr_ready_o=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: four-cycle issue/writeback controller for an external
// combinational ALU. Accepts R-type words, reads operands from a local
// register file, drives the ALU, then writes the result back.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a new instruction; word latched on handshake
// READ   | decode funct, read rs/rt (or shamt), register ALU inputs
// EXEC   | ALU inputs stable; result and flags sampled at cycle end
// WB     | write rd (legal, rd!=0), pulse done_o, back to IDLE
module alu_issue_ctrl #(
  parameter int NREG = 32,
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            instr_valid_i,
  output logic            instr_ready_o,
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] opr_a_alu_o,
  output logic [XLEN-1:0] opr_b_alu_o,
  output logic [5:0]      op_alu_o,
  input  logic [XLEN-1:0] res_alu_i,
  input  logic            z_alu_i,
  input  logic            n_alu_i,
  output logic            done_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] res_o,
  output logic            z_o,
  output logic            n_o,
  input  logic [4:0]      dbg_addr_i,
  output logic [XLEN-1:0] dbg_data_o
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SHL  = 6'b000010;
  localparam logic [5:0] F_LSR  = 6'b000011;
  localparam logic [5:0] F_ASR  = 6'b000100;

  state_t          r_state;
  state_t          w_next_state;
  logic [31:0]     r_instr;
  logic            r_illegal;
  logic [XLEN-1:0] r_regs [NREG];

  logic [5:0]      w_opcode;
  logic [4:0]      w_rs;
  logic [4:0]      w_rt;
  logic [4:0]      w_rd;
  logic [4:0]      w_shamt;
  logic [5:0]      w_funct;
  logic            w_legal;
  logic            w_is_shift;

  assign w_opcode = r_instr[31:26];
  assign w_rs     = r_instr[25:21];
  assign w_rt     = r_instr[20:16];
  assign w_rd     = r_instr[15:11];
  assign w_shamt  = r_instr[10:6];
  assign w_funct  = r_instr[5:0];

  // Decode legality and shift class from the latched word.
  always_comb begin
    w_legal    = 1'b0;
    w_is_shift = 1'b0;
    case (w_funct)
      F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU:
        w_legal = (w_opcode == 6'b000000);
      F_SHL, F_LSR, F_ASR: begin
        w_legal    = (w_opcode == 6'b000000);
        w_is_shift = 1'b1;
      end
      default: begin
        w_legal    = 1'b0;
        w_is_shift = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state and handshake/completion outputs.
  always_comb begin
    w_next_state  = r_state;
    instr_ready_o = 1'b0;
    done_o        = 1'b0;
    illegal_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) w_next_state = S_READ;
      end
      S_READ: w_next_state = S_EXEC;
      S_EXEC: w_next_state = S_WB;
      S_WB: begin
        done_o       = 1'b1;
        illegal_o    = r_illegal;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath: instruction latch, ALU input registers, result capture, register file.
  // res_o/z_o/n_o load entering WB so they are already valid while done_o is high;
  // the register file then takes res_o at the end of WB.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_instr     <= '0;
      r_illegal   <= 1'b0;
      opr_a_alu_o <= '0;
      opr_b_alu_o <= '0;
      op_alu_o    <= '0;
      res_o       <= '0;
      z_o         <= 1'b0;
      n_o         <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      if (r_state == S_IDLE && instr_valid_i) r_instr <= instr_i;
      if (r_state == S_READ) begin
        op_alu_o    <= w_funct;
        opr_a_alu_o <= r_regs[w_rs];
        opr_b_alu_o <= w_is_shift ? {{(XLEN-5){1'b0}}, w_shamt} : r_regs[w_rt];
        r_illegal   <= !w_legal;
      end
      if (r_state == S_EXEC && !r_illegal) begin
        res_o <= res_alu_i;
        z_o   <= z_alu_i;
        n_o   <= n_alu_i;
      end
      if (r_state == S_WB && !r_illegal && w_rd != 5'd0) r_regs[w_rd] <= res_o;
    end
  end

  // Debug read port; register 0 always reads zero.
  always_comb begin
    dbg_data_o = '0;
    if (dbg_addr_i != 5'd0) dbg_data_o = r_regs[dbg_addr_i];
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a behavioural ALU sits on the DUT's
// ALU ports, and a reference register model predicts each completion.
module tb_alu_issue_ctrl;

  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_XOR  = 6'b100110;
  localparam logic [5:0] F_NOR  = 6'b100111;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;
  localparam logic [5:0] F_SHL  = 6'b000010;
  localparam logic [5:0] F_LSR  = 6'b000011;
  localparam logic [5:0] F_ASR  = 6'b000100;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_valid_i;
  logic        instr_ready_o;
  logic [31:0] instr_i;
  logic [31:0] opr_a_alu_o, opr_b_alu_o;
  logic [5:0]  op_alu_o;
  logic [31:0] res_alu_i;
  logic        z_alu_i, n_alu_i;
  logic        done_o, illegal_o;
  logic [31:0] res_o;
  logic        z_o, n_o;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_data_o;

  alu_issue_ctrl #(.NREG(32), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o), .instr_i(instr_i),
    .opr_a_alu_o(opr_a_alu_o), .opr_b_alu_o(opr_b_alu_o), .op_alu_o(op_alu_o),
    .res_alu_i(res_alu_i), .z_alu_i(z_alu_i), .n_alu_i(n_alu_i),
    .done_o(done_o), .illegal_o(illegal_o), .res_o(res_o), .z_o(z_o), .n_o(n_o),
    .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      F_ADD:  return a + b;
      F_SUB:  return a - b;
      F_AND:  return a & b;
      F_OR:   return a | b;
      F_XOR:  return a ^ b;
      F_NOR:  return ~(a | b);
      F_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      F_SLTU: return (a < b) ? 32'd1 : 32'd0;
      F_SHL:  return a << b[4:0];
      F_LSR:  return a >> b[4:0];
      F_ASR:  return 32'($signed(a) >>> b[4:0]);
      default: return 32'd0;
    endcase
  endfunction

  // Behavioural ALU attached to the DUT.
  always_comb begin
    res_alu_i = alu_ref(op_alu_o, opr_a_alu_o, opr_b_alu_o);
    z_alu_i   = (res_alu_i == 32'd0);
    n_alu_i   = res_alu_i[31];
  end

  function automatic logic [31:0] enc(input logic [5:0] opc, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {opc, rs, rt, rd, sh, fn};
  endfunction

  function automatic bit is_legal(input logic [31:0] w);
    return (w[31:26] == 6'd0) &&
           (w[5:0] inside {F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU, F_SHL, F_LSR, F_ASR});
  endfunction

  function automatic logic [5:0] pick_funct(input int k);
    case (k)
      0: return F_ADD;  1: return F_SUB;  2: return F_AND;  3: return F_OR;
      4: return F_XOR;  5: return F_NOR;  6: return F_SLT;  7: return F_SLTU;
      8: return F_SHL;  9: return F_LSR;  default: return F_ASR;
    endcase
  endfunction

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        n;
    logic        ill;
    logic [4:0]  rd;
    logic [31:0] rdval;
    int          hs;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_reg [32];
  logic [31:0] m_res;
  logic        m_z, m_n;
  int          last_hs;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
    m_res = 32'd0; m_z = 1'b0; m_n = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] w, input int hs);
    exp_t        e;
    logic [31:0] a, b, r;
    logic [5:0]  fn;
    logic [4:0]  rd;
    fn = w[5:0];
    rd = w[15:11];
    e.hs  = hs;
    e.rd  = rd;
    e.ill = !is_legal(w);
    if (!e.ill) begin
      a = m_reg[w[25:21]];
      b = (fn == F_SHL || fn == F_LSR || fn == F_ASR) ? {27'd0, w[10:6]} : m_reg[w[20:16]];
      r = alu_ref(fn, a, b);
      if (rd != 5'd0) m_reg[rd] = r;
      m_res = r; m_z = (r == 32'd0); m_n = r[31];
    end
    e.res = m_res; e.z = m_z; e.n = m_n;
    e.rdval = m_reg[rd];
    sb.push_back(e);
  endtask

  // Drive one word; while ready is low the word bus carries garbage.
  task automatic send(input logic [31:0] w, input bit keep, input bit track);
    int t;
    t = 0;
    @(negedge clk_i);
    instr_valid_i = 1'b1;
    while (!instr_ready_o && t < 20) begin
      instr_i = $urandom;
      @(negedge clk_i);
      t++;
    end
    check_eq("ready_wait_bounded", 32'(t < 20), 32'd1);
    instr_i = w;
    if (track) begin
      if (keep && last_hs >= 0) check_eq("b2b_spacing", 32'(cyc - last_hs), 32'd4);
      last_hs = cyc;
      push_exp(w, cyc);
    end
    @(posedge clk_i);
    #1;
    instr_i = $urandom;
    if (!keep) instr_valid_i = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(negedge clk_i);
      t++;
    end
    check_eq("drain_bounded", 32'(t < 60), 32'd1);
    @(negedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic dbg_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    dbg_addr_i = addr;
    #1;
    check_eq(tag, dbg_data_o, exp);
  endtask

  // Completion monitor: pops the scoreboard on every done_o pulse.
  always begin
    exp_t e;
    @(negedge clk_i);
    if (done_o && !rst_i) begin
      if (sb.size() == 0) begin
        check_eq("done_unexpected", 32'(done_o), 32'd0);
      end else begin
        e = sb.pop_front();
        check_eq("latency", 32'(cyc - e.hs), 32'd3);
        check_eq("illegal_o", 32'(illegal_o), 32'(e.ill));
        dbg_addr_i = e.rd;
        @(negedge clk_i);
        check_eq("done_single_pulse", 32'(done_o), 32'd0);
        check_eq("res_o", res_o, e.res);
        check_eq("z_o", 32'(z_o), 32'(e.z));
        check_eq("n_o", 32'(n_o), 32'(e.n));
        check_eq("wb_dbg", dbg_data_o, e.rdval);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    rst_i = 1'b1; instr_valid_i = 1'b0; instr_i = 32'd0; dbg_addr_i = 5'd0;
    last_hs = -1;
    model_reset();
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_ready", 32'(instr_ready_o), 32'd1);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_illegal", 32'(illegal_o), 32'd0);
    check_eq("rst_res", res_o, 32'd0);
    check_eq("rst_zn", {30'd0, z_o, n_o}, 32'd0);
    check_eq("rst_opr_a", opr_a_alu_o, 32'd0);
    check_eq("rst_opr_b", opr_b_alu_o, 32'd0);
    check_eq("rst_op", 32'(op_alu_o), 32'd0);
    dbg_chk("rst_r5", 5'd5, 32'd0);

    // Build R1=5, R2=7, then R3=R1+R2.
    send(enc(6'd0, 5'd0,  5'd0,  5'd9,  5'd0,  F_NOR), 1'b0, 1'b1);
    send(enc(6'd0, 5'd9,  5'd0,  5'd2,  5'd29, F_LSR), 1'b0, 1'b1);
    send(enc(6'd0, 5'd9,  5'd0,  5'd10, 5'd31, F_LSR), 1'b0, 1'b1);
    send(enc(6'd0, 5'd10, 5'd0,  5'd11, 5'd2,  F_SHL), 1'b0, 1'b1);
    send(enc(6'd0, 5'd11, 5'd10, 5'd1,  5'd0,  F_ADD), 1'b0, 1'b1);
    send(enc(6'd0, 5'd1,  5'd2,  5'd3,  5'd0,  F_ADD), 1'b0, 1'b1);
    drain();
    dbg_chk("r1_is_5", 5'd1, 32'd5);
    dbg_chk("r2_is_7", 5'd2, 32'd7);
    dbg_chk("r3_is_12", 5'd3, 32'd12);
    check_eq("add_res", res_o, 32'd12);
    check_eq("add_z", 32'(z_o), 32'd0);

    send(enc(6'd0, 5'd3, 5'd3, 5'd4, 5'd0, F_SUB), 1'b0, 1'b1);
    drain();
    check_eq("sub_res", res_o, 32'd0);
    check_eq("sub_z", 32'(z_o), 32'd1);
    dbg_chk("r4_is_0", 5'd4, 32'd0);

    send(enc(6'd0, 5'd0, 5'd0, 5'd1, 5'd0,  F_NOR),  1'b0, 1'b1);
    send(enc(6'd0, 5'd1, 5'd0, 5'd2, 5'd31, F_LSR),  1'b0, 1'b1);
    send(enc(6'd0, 5'd1, 5'd2, 5'd6, 5'd0,  F_SLT),  1'b0, 1'b1);
    send(enc(6'd0, 5'd1, 5'd2, 5'd7, 5'd0,  F_SLTU), 1'b0, 1'b1);
    drain();
    dbg_chk("slt_r6", 5'd6, 32'd1);
    dbg_chk("sltu_r7", 5'd7, 32'd0);

    send(enc(6'd0, 5'd2, 5'd0, 5'd1, 5'd31, F_SHL), 1'b0, 1'b1);
    send(enc(6'd0, 5'd1, 5'd2, 5'd8, 5'd4,  F_ASR), 1'b0, 1'b1);
    drain();
    dbg_chk("asr_r8", 5'd8, 32'hF800_0000);
    check_eq("asr_n", 32'(n_o), 32'd1);
    send(enc(6'd0, 5'd1, 5'd3, 5'd8, 5'd4, F_LSR), 1'b0, 1'b1);
    drain();
    dbg_chk("lsr_r8", 5'd8, 32'h0800_0000);
    send(enc(6'd0, 5'd1, 5'd4, 5'd8, 5'd1, F_SHL), 1'b0, 1'b1);
    drain();
    dbg_chk("shl_r8", 5'd8, 32'd0);
    check_eq("shl_z", 32'(z_o), 32'd1);

    send(enc(6'd0, 5'd1, 5'd2, 5'd0, 5'd0, F_ADD), 1'b0, 1'b1);
    drain();
    dbg_chk("r0_stays_0", 5'd0, 32'd0);
    check_eq("rd0_res", res_o, 32'h8000_0001);

    send(enc(6'b001000, 5'd1, 5'd2, 5'd5, 5'd0, F_ADD), 1'b0, 1'b1);
    send(enc(6'd0, 5'd1, 5'd2, 5'd6, 5'd0, 6'b111111), 1'b0, 1'b1);
    drain();
    check_eq("illegal_res_held", res_o, 32'h8000_0001);
    dbg_chk("illegal_r5", 5'd5, 32'd0);
    dbg_chk("illegal_r6", 5'd6, 32'd1);

    // Back-to-back stream with valid held high.
    last_hs = -1;
    for (int i = 0; i < 10; i++) begin
      w = enc(($urandom_range(3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0,
              5'($urandom_range(31)), 5'($urandom_range(31)), 5'($urandom_range(31)),
              5'($urandom_range(31)),
              ($urandom_range(7) == 0) ? 6'b111111 : pick_funct(int'($urandom_range(10))));
      send(w, (i < 9), 1'b1);
    end
    drain();
    for (int r = 0; r < 32; r++) dbg_chk("regfile_final", 5'(r), m_reg[r]);

    // Reset during EXEC aborts the instruction.
    send(enc(6'd0, 5'd1, 5'd2, 5'd5, 5'd0, F_ADD), 1'b0, 1'b0);
    @(posedge clk_i);
    #1 rst_i = 1'b1;
    @(negedge clk_i);
    check_eq("rst_mid_no_done", 32'(done_o), 32'd0);
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    model_reset();
    @(negedge clk_i);
    check_eq("rst_mid_ready", 32'(instr_ready_o), 32'd1);
    check_eq("rst_mid_done", 32'(done_o), 32'd0);
    check_eq("rst_mid_res", res_o, 32'd0);
    dbg_chk("rst_mid_r5", 5'd5, 32'd0);
    repeat (3) begin
      @(negedge clk_i);
      check_eq("rst_mid_quiet", 32'(done_o), 32'd0);
    end

    send(enc(6'd0, 5'd0, 5'd0, 5'd1, 5'd0, F_NOR), 1'b0, 1'b1);
    drain();
    dbg_chk("post_rst_r1", 5'd1, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
